// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
// Shared definitions for the mux scan sequencer and its settle timer.
//   N_CH_DEF / SEL_W_DEF : default channel count and select width
//   SETTLE_MAX           : largest legal settle time (fits the 4-bit timer)
//   scan_state_e         : sequencer FSM encoding
package mux_scan_pkg;

  localparam int N_CH_DEF     = 32;
  localparam int SEL_W_DEF    = 5;
  localparam int SETTLE_MAX   = 15;
  localparam int SETTLE_CNT_W = 4;

  // State names carry an ST_ prefix so they never collide with the
  // SETTLE parameter of the modules that import this package.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_e;

  // State a channel visit starts in: with no settle time the select is
  // sampled straight away.
  function automatic scan_state_e scan_entry_state(input int settle);
    return (settle == 0) ? ST_SAMPLE : ST_SETTLE;
  endfunction

endpackage

// File: rtl/mux_scan_settle_timer.sv
// mux_scan_settle_timer
// Counts the settle cycles spent on one mux channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the count back to 0 (has priority over en)
//   en         : advance the count by one
//   done       : count has reached SETTLE-1; constant 1 when SETTLE==0
module mux_scan_settle_timer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [SETTLE_CNT_W-1:0] LAST_CNT =
    SETTLE_CNT_W'((SETTLE == 0) ? 0 : SETTLE - 1);

  logic [SETTLE_CNT_W-1:0] count_q;
  logic [SETTLE_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + SETTLE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // With no settle time every cycle is a sample cycle, so the timer is
  // permanently finished.
  generate
    if (SETTLE == 0) begin : g_no_settle
      assign done = 1'b1;
    end else begin : g_settle
      assign done = (count_q == LAST_CNT);
    end
  endgenerate

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
// Steps a 32:1 mux select through every channel, waits SETTLE cycles after
// each select change, samples the mux output and packs the results into a
// frame word delivered on a valid/ready interface. Single-shot or
// continuous scanning.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a scan (only looked at in IDLE)
//   cont         : continuous mode, looked at on the frame handshake
//   mux_sel      : registered select to the mux
//   mux_y        : mux output
//   frame_data   : bit k = mux_y sampled while mux_sel==k
//   frame_valid  : frame_data holds a complete frame
//   frame_ready  : consumer accepts the frame
//   busy         : high in every state except IDLE
// Optional: define MUX_SCAN_PARITY_EN to add frame_parity, the XOR of all
// frame bits, registered together with frame_data.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_y,
  output logic [N_CH-1:0]  frame_data,
`ifdef MUX_SCAN_PARITY_EN
  output logic             frame_parity,
`endif
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             busy
);

  localparam scan_state_e      SCAN_ENTRY = scan_entry_state(SETTLE);
  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(N_CH - 1);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] channel_q, channel_d;
  logic [N_CH-1:0]  shadow_q, shadow_d;
  logic [N_CH-1:0]  frame_data_q, frame_data_d;
  logic             frame_valid_q, frame_valid_d;

  logic settle_done;
  logic timer_clr;
  logic timer_en;

  // The timer only runs while settling and is parked at 0 everywhere else,
  // so every channel visit starts from a clean count.
  assign timer_en  = (state_q == ST_SETTLE);
  assign timer_clr = (state_q != ST_SETTLE) || settle_done;

  mux_scan_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .done  (settle_done)
  );

  always_comb begin
    state_d       = state_q;
    channel_d     = channel_q;
    shadow_d      = shadow_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          channel_d = '0;
          state_d   = SCAN_ENTRY;
        end
      end

      ST_SETTLE: begin
        if (settle_done) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        shadow_d[channel_q] = mux_y;
        if (channel_q == LAST_CH) begin
          // The last bit comes straight from the mux; the shadow copy of it
          // is only written on this same edge.
          frame_data_d           = shadow_q;
          frame_data_d[N_CH-1]   = mux_y;
          frame_valid_d          = 1'b1;
          state_d                = ST_DONE;
        end else begin
          channel_d = channel_q + SEL_W'(1);
          state_d   = SCAN_ENTRY;
        end
      end

      ST_DONE: begin
        // The select stays on the last channel until the frame is taken;
        // start is deliberately not looked at here.
        if (frame_ready) begin
          frame_valid_d = 1'b0;
          channel_d     = '0;
          state_d       = cont ? SCAN_ENTRY : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      channel_q     <= '0;
      shadow_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      channel_q     <= channel_d;
      shadow_q      <= shadow_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic frame_parity_q;
  logic frame_parity_d;

  // Follows frame_data_d, so it changes on exactly the edges frame_data does.
  assign frame_parity_d = ^frame_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_parity_q <= 1'b0;
    end else begin
      frame_parity_q <= frame_parity_d;
    end
  end

  assign frame_parity = frame_parity_q;
`endif

  // The channel register doubles as the mux select.
  assign mux_sel     = channel_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer
// Two sequencer instances: dut_a with the default settle time of 2 and
// dut_b with no settle time. The bench plays the 32:1 mux: mux_y is bit
// mux_sel of a pattern word, optionally inverted while the select is still
// settling on dut_a. Define MUX_SCAN_PARITY_EN to also check frame_parity.
`timescale 1ns/1ps
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        frame_ready = 1'b0;
  logic        use_s0 = 1'b0;
  logic [31:0] pat = '0;
  logic        corrupt_en = 1'b0;

  logic [4:0]  sel_a, sel_b;
  logic        y_a, y_b;
  logic [31:0] data_a, data_b;
  logic        valid_a, valid_b;
  logic        busy_a, busy_b;
`ifdef MUX_SCAN_PARITY_EN
  logic        par_a, par_b;
`endif

  int errors = 0;
  int checks = 0;

  // Cycles since dut_a's select last changed (or since it left IDLE).
  int          age = 100;
  logic [4:0]  last_sel = '0;
  logic        last_busy = 1'b0;

  always @(negedge clk) begin
    if (sel_a !== last_sel || (busy_a && !last_busy)) age = 0;
    else if (age < 100) age = age + 1;
    last_sel  = sel_a;
    last_busy = busy_a;
  end

  assign y_a = pat[sel_a] ^ (corrupt_en && (age < 2));
  assign y_b = pat[sel_b];

  mux_scan_sequencer dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start && !use_s0),
    .cont         (cont),
    .mux_sel      (sel_a),
    .mux_y        (y_a),
    .frame_data   (data_a),
`ifdef MUX_SCAN_PARITY_EN
    .frame_parity (par_a),
`endif
    .frame_valid  (valid_a),
    .frame_ready  (frame_ready && !use_s0),
    .busy         (busy_a)
  );

  mux_scan_sequencer #(
    .SETTLE (0)
  ) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start && use_s0),
    .cont         (cont),
    .mux_sel      (sel_b),
    .mux_y        (y_b),
    .frame_data   (data_b),
`ifdef MUX_SCAN_PARITY_EN
    .frame_parity (par_b),
`endif
    .frame_valid  (valid_b),
    .frame_ready  (frame_ready && use_s0),
    .busy         (busy_b)
  );

  logic [4:0]  v_sel;
  logic [31:0] v_data;
  logic        v_valid, v_busy;
  assign v_sel   = use_s0 ? sel_b   : sel_a;
  assign v_data  = use_s0 ? data_b  : data_a;
  assign v_valid = use_s0 ? valid_b : valid_a;
  assign v_busy  = use_s0 ? busy_b  : busy_a;
`ifdef MUX_SCAN_PARITY_EN
  logic v_par;
  assign v_par = use_s0 ? par_b : par_a;
`endif

  typedef struct {
    logic [31:0] pattern;
    logic        corrupt;
    logic        noise;
    int          ready_delay;
    logic        cont;
    logic [31:0] exp_frame;
  } vec_t;

  // ---------------- reference model ----------------
  function automatic int settleNow();
    return use_s0 ? 0 : 2;
  endfunction

  // Each channel occupies settle+1 cycles; the select moves on at the end
  // of each visit and parks on the last channel once the frame is complete.
  function automatic int expSel(input int t, input int s);
    int c;
    c = t / (s + 1);
    return (c > 31) ? 31 : c;
  endfunction

  // Frame bit k is what the mux showed on channel k.
  function automatic logic [31:0] modelFrame(input logic [31:0] p);
    logic [31:0] f;
    f = '0;
    for (int ch = 0; ch < 32; ch++) f[ch] = p[ch];
    return f;
  endfunction

  function automatic logic expParity(input logic [31:0] f);
    return ($countones(f) % 2) == 1;
  endfunction

  // ---------------- helpers ----------------
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] p, input logic corrupt);
    pat        = p;
    corrupt_en = corrupt;
  endtask

  task automatic pulseStart();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_sel"},   32'(v_sel),   32'd0);
    checkOutput({tag, "_data"},  v_data,       32'd0);
    checkOutput({tag, "_valid"}, 32'(v_valid), 32'd0);
    checkOutput({tag, "_busy"},  32'(v_busy),  32'd0);
`ifdef MUX_SCAN_PARITY_EN
    checkOutput({tag, "_parity"}, 32'(v_par), 32'd0);
`endif
  endtask

  // Called one step after the edge that starts a scan. With noise set,
  // start, cont and frame_ready wiggle randomly while no frame is offered.
  task automatic waitFrame(input logic [31:0] exp_frame, input logic noise);
    int s, lat, t, bad;
    s   = settleNow();
    lat = 32 * (s + 1);
    t   = 0;
    bad = 0;
    while (t < lat + 20) begin
      @(posedge clk); #1;
      t++;
      if (v_valid) break;
      if (v_sel !== 5'(expSel(t, s))) bad++;
      frame_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      start       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      cont        = noise ? 1'($urandom_range(0, 1)) : cont;
    end
    frame_ready = 1'b0;
    start       = 1'b0;
    checkOutput("latency", 32'(t), 32'(lat));
    checkOutput("sel_trace_errs", 32'(bad), 32'd0);
    checkOutput("frame_data", v_data, exp_frame);
    checkOutput("sel_at_done", 32'(v_sel), 32'd31);
    checkOutput("busy_in_done", 32'(v_busy), 32'd1);
`ifdef MUX_SCAN_PARITY_EN
    checkOutput("frame_parity", 32'(v_par), 32'(expParity(exp_frame)));
`endif
  endtask

  task automatic handshake(input int delay, input logic c,
                           input logic [31:0] exp_frame, input logic noise);
    int unstable;
    unstable = 0;
    for (int i = 0; i < delay; i++) begin
      if (noise) cont = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (!v_valid || v_data !== exp_frame || v_sel !== 5'd31) unstable++;
    end
    checkOutput("hold_violations", 32'(unstable), 32'd0);
    cont        = c;
    frame_ready = 1'b1;
    start       = noise;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    start       = 1'b0;
    checkOutput("valid_after_hs", 32'(v_valid), 32'd0);
    checkOutput("sel_after_hs", 32'(v_sel), 32'd0);
    checkOutput("busy_after_hs", 32'(v_busy), 32'(c));
  endtask

  task automatic runVector(input vec_t v);
    applyStimulus(v.pattern, v.corrupt);
    if (!v_busy) pulseStart();
    waitFrame(v.exp_frame, v.noise);
    handshake(v.ready_delay, v.cont, v.exp_frame, v.noise);
  endtask

  // ---------------- test sequence ----------------
  vec_t table_a[6];
  vec_t table_b[3];
  vec_t rv;

  initial begin
    table_a[0] = '{32'hA5C3_0F81, 1'b0, 1'b0, 0,  1'b0, 32'hA5C3_0F81};
    table_a[1] = '{32'hA5C3_0F81, 1'b1, 1'b0, 0,  1'b0, 32'hA5C3_0F81};
    table_a[2] = '{32'h1234_5678, 1'b1, 1'b0, 20, 1'b1, 32'h1234_5678};
    table_a[3] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 3,  1'b1, 32'hFFFF_FFFF};
    table_a[4] = '{32'h8000_0001, 1'b1, 1'b1, 1,  1'b0, 32'h8000_0001};
    table_a[5] = '{32'h0000_0000, 1'b1, 1'b0, 2,  1'b0, 32'h0000_0000};
    table_b[0] = '{32'h0000_0001, 1'b0, 1'b0, 0,  1'b0, 32'h0000_0001};
    table_b[1] = '{32'hDEAD_BEEF, 1'b0, 1'b1, 4,  1'b1, 32'hDEAD_BEEF};
    table_b[2] = '{32'h7FFF_FFFE, 1'b0, 1'b0, 0,  1'b0, 32'h7FFF_FFFE};

    $display("[TB] reset state");
    #12;
    use_s0 = 1'b0; #1 checkIdleOutputs("reset_a");
    use_s0 = 1'b1; #1 checkIdleOutputs("reset_b");
    use_s0 = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    $display("[TB] table vectors, settle 2");
    foreach (table_a[i]) runVector(table_a[i]);

    $display("[TB] random frames, settle 2");
    for (int i = 0; i < 8; i++) begin
      rv.pattern     = $urandom;
      rv.corrupt     = 1'($urandom_range(0, 1));
      rv.noise       = 1'($urandom_range(0, 1));
      rv.ready_delay = $urandom_range(0, 4);
      rv.cont        = (i == 7) ? 1'b0 : 1'($urandom_range(0, 1));
      rv.exp_frame   = modelFrame(rv.pattern);
      runVector(rv);
    end

    $display("[TB] reset in the middle of a scan");
    begin
      int waited;
      logic seen;
      applyStimulus(32'h0F0F_3C3C, 1'b1);
      pulseStart();
      waited = 0;
      seen   = 1'b0;
      while (waited < 200) begin
        @(posedge clk); #1;
        waited++;
        if (sel_a == 5'd17) begin
          seen = 1'b1;
          break;
        end
      end
      checkOutput("reach_ch17", 32'(seen), 32'd1);
      #2 rst_n = 1'b0;
      #1 checkIdleOutputs("midscan_reset");
      @(posedge clk); #1 checkIdleOutputs("held_reset");
      @(negedge clk) rst_n = 1'b1;
      applyStimulus(32'h0000_F00F, 1'b1);
      pulseStart();
      waitFrame(modelFrame(32'h0000_F00F), 1'b0);
      handshake(0, 1'b0, modelFrame(32'h0000_F00F), 1'b0);
    end

    $display("[TB] table vectors, settle 0");
    use_s0 = 1'b1;
    corrupt_en = 1'b0;
    foreach (table_b[i]) runVector(table_b[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
